reorder_buffer: RTL
===================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, 16, number of entries (power of two, >=4).
REQ-002 SHALL have parameter NCDB, 2, number of result-broadcast (CDB) ports.
REQ-003 SHALL have parameter XLEN, 32, data/PC width.
REQ-004 SHALL derive TAGW=log2(DEPTH) and CNTW=log2(DEPTH)+1.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports (name dir width meaning): clk in 1 clock; rst in 1 sync active-high reset; rdy in 1 global enable, low freezes all state and outputs.
REQ-007 SHALL have issue ports: is_valid in 1; is_ready in 1 result known at issue; is_op in 6 opcode class; is_value in XLEN result, or producer tag in [TAGW-1:0] for an unready store; is_dest in 5; is_pred_taken in 1; is_alt_pc in XLEN redirect PC if mispredicted; is_tag out TAGW tag assigned this cycle.
REQ-008 SHALL have status ports: full out 1; count out CNTW occupied entries.
REQ-009 SHALL have CDB ports: cdb_valid in NCDB; cdb_tag in NCDB*TAGW; cdb_result in NCDB*XLEN.
REQ-010 SHALL have operand query ports qtag1/qtag2 in TAGW, and outputs qrdy1/qrdy2 out 1 and qval1/qval2 out XLEN.
REQ-011 SHALL have commit ports: cm_reg_valid out 1; cm_st_valid out 1; cm_dest out 5; cm_value out XLEN; cm_tag out TAGW; flush out 1; flush_pc out XLEN.

Function
REQ-012 SHALL be a circular buffer with head/tail pointers and an explicit counter; full = (count==DEPTH), so all DEPTH entries are usable.
REQ-013 SHALL present is_tag = tail combinationally, and on an edge with rdy && is_valid && !full SHALL write the entry at tail and advance tail modulo DEPTH.
REQ-014 SHALL ignore is_valid while full, with no state change.
REQ-015 SHALL, for each CDB port p with cdb_valid[p], set ready and value on the occupied, not-ready, non-STORE entry whose tag matches; if ports collide on one tag, the highest index wins.
REQ-016 SHALL, for each occupied, not-ready STORE entry whose value[TAGW-1:0] equals a valid cdb_tag, capture that cdb_result and set ready.
REQ-017 SHALL NOT apply CDB updates to the entry being allocated in the same cycle; the issue stage resolves that case.
REQ-018 SHALL answer queries combinationally: qrdy = entry ready OR a valid CDB port targets qtag this cycle (CDB forwarding, highest port wins); qval selects accordingly.
REQ-019 SHALL retire at most one entry per cycle, when count!=0 and the head entry is ready; commit outputs are registered and visible the cycle after the retiring edge.
REQ-020 SHALL pulse cm_reg_valid for LUI/AUIPC/JAL/JALR/LOAD/ITYPE/RTYPE and cm_st_valid for STORE, with neither for BTYPE; both are 0 in any cycle with no retirement.
REQ-021 SHALL treat a retiring BTYPE with value[0] != pred_taken as a mispredict: flush=1 and flush_pc=alt_pc for exactly one cycle.
REQ-022 SHALL, on the mispredict retiring edge, reset head, tail and count to 0 and clear all ready bits; a same-edge allocation is discarded.
REQ-023 SHALL update count as +1 (alloc only), -1 (retire only), or unchanged (both) on simultaneous allocate and retire, and alloc SHALL be accepted when full and retiring only if full is sampled low, i.e. never.
REQ-024 SHALL freeze all state and registered outputs while rdy=0, including the one-cycle pulses, which are held.

Reset
REQ-025 SHALL, on rst, set head=tail=count=0 and clear all ready bits.
REQ-026 SHALL, on rst, drive cm_reg_valid, cm_st_valid and flush to 0, and cm_dest, cm_value, cm_tag and flush_pc to 0.
REQ-027 SHALL give rst priority over rdy and over any in-flight operation; entry payload arrays need no reset.

Structure
REQ-028 SHALL take opcode-class constants (LUI, AUIPC, JAL, JALR, BTYPE, LTYPE, STYPE, ITYPE, RTYPE; 6-bit) from shared package rob_pkg, which also holds the TAGW/CNTW derivation.
REQ-029 SHALL place query lookup plus CDB forwarding in one sub-module, rob_query_port, instantiated twice.

Verification (DEPTH=4, NCDB=2)
REQ-030 SHALL test: 4 issues then a 5th with is_valid=1 -> tags 0..3, full=1, count=4, the 5th is ignored, and tail is unchanged.
REQ-031 SHALL test: a STORE issued unready with value=2, then cdb_valid[0] tag2 result 0xAB -> the store entry becomes ready with value 0xAB, and cm_st_valid pulses once on retirement.
REQ-032 SHALL test: qtag1=1 unready while cdb_valid[1] tag1 result 0x55 -> qrdy1=1 and qval1=0x55 in the same cycle.
REQ-033 SHALL test: a retiring BTYPE with value[0]=1, pred=0, alt_pc=0x100 -> the next cycle has flush=1 and flush_pc=0x100, count=0, and a same-edge issue is dropped.
REQ-034 SHALL test: head at 3 with allocate and retire on the same edge -> the pointers wrap to 0 and count is unchanged.
REQ-035 SHALL test: rst asserted mid-stream with rdy=0 -> all outputs are 0 and count=0 on the next cycle.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer: opcode classes,
// tag/count width helpers and the register-writeback classifier.
package rob_pkg;

  localparam logic [5:0] LUI   = 6'd1;
  localparam logic [5:0] AUIPC = 6'd2;
  localparam logic [5:0] JAL   = 6'd3;
  localparam logic [5:0] JALR  = 6'd4;
  localparam logic [5:0] BTYPE = 6'd5;
  localparam logic [5:0] LTYPE = 6'd6;
  localparam logic [5:0] STYPE = 6'd7;
  localparam logic [5:0] ITYPE = 6'd8;
  localparam logic [5:0] RTYPE = 6'd9;

  function automatic int tag_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic writes_reg(input logic [5:0] op);
    case (op)
      LUI, AUIPC, JAL, JALR,
      LTYPE, ITYPE, RTYPE: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rob_query_port.sv
// Operand query: entry lookup with same-cycle CDB forwarding.
// Ports: qtag_i, entry ready/value vectors, CDB bus in; qrdy_o/qval_o out.
module rob_query_port
  import rob_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int NCDB  = 2,
  parameter int XLEN  = 32,
  parameter int TAGW  = 4
) (
  input  logic [TAGW-1:0]             qtag_i,
  input  logic [DEPTH-1:0]            ready_i,
  input  logic [DEPTH-1:0][XLEN-1:0]  value_i,
  input  logic [NCDB-1:0]             cdb_valid_i,
  input  logic [NCDB*TAGW-1:0]        cdb_tag_i,
  input  logic [NCDB*XLEN-1:0]        cdb_result_i,
  output logic                        qrdy_o,
  output logic [XLEN-1:0]             qval_o
);

  logic            fwd_hit;
  logic [XLEN-1:0] fwd_val;

  // Ascending scan so the highest matching port wins.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_val = '0;
    for (int p = 0; p < NCDB; p++) begin
      if (cdb_valid_i[p] &&
          cdb_tag_i[p*TAGW +: TAGW] == qtag_i) begin
        fwd_hit = 1'b1;
        fwd_val = cdb_result_i[p*XLEN +: XLEN];
      end
    end
  end

  assign qrdy_o = ready_i[qtag_i] | fwd_hit;
  assign qval_o = ready_i[qtag_i] ? value_i[qtag_i]
                                  : fwd_val;

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order issue, CDB wakeup, in-order retire
// with branch-mispredict flush. Ports: issue, status, CDB, 2 queries, commit.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int NCDB  = 2,
  parameter  int XLEN  = 32,
  localparam int TAGW  = tag_w(DEPTH),
  localparam int CNTW  = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  is_valid,
  input  logic                  is_ready,
  input  logic [5:0]            is_op,
  input  logic [XLEN-1:0]       is_value,
  input  logic [4:0]            is_dest,
  input  logic                  is_pred_taken,
  input  logic [XLEN-1:0]       is_alt_pc,
  output logic [TAGW-1:0]       is_tag,
  output logic                  full,
  output logic [CNTW-1:0]       count,
  input  logic [NCDB-1:0]       cdb_valid,
  input  logic [NCDB*TAGW-1:0]  cdb_tag,
  input  logic [NCDB*XLEN-1:0]  cdb_result,
  input  logic [TAGW-1:0]       qtag1,
  input  logic [TAGW-1:0]       qtag2,
  output logic                  qrdy1,
  output logic                  qrdy2,
  output logic [XLEN-1:0]       qval1,
  output logic [XLEN-1:0]       qval2,
  output logic                  cm_reg_valid,
  output logic                  cm_st_valid,
  output logic [4:0]            cm_dest,
  output logic [XLEN-1:0]       cm_value,
  output logic [TAGW-1:0]       cm_tag,
  output logic                  flush,
  output logic [XLEN-1:0]       flush_pc
);

  logic [TAGW-1:0]             head_q, head_d;
  logic [TAGW-1:0]             tail_q, tail_d;
  logic [CNTW-1:0]             count_q, count_d;
  logic [DEPTH-1:0]            ready_q, ready_d;
  logic [DEPTH-1:0][XLEN-1:0]  value_q, value_d;
  logic [DEPTH-1:0][XLEN-1:0]  alt_q, alt_d;
  logic [DEPTH-1:0][5:0]       op_q, op_d;
  logic [DEPTH-1:0][4:0]       dest_q, dest_d;
  logic [DEPTH-1:0]            pred_q, pred_d;

  logic                        cm_reg_q, cm_reg_d;
  logic                        cm_st_q, cm_st_d;
  logic                        flush_q, flush_d;
  logic [4:0]                  cm_dest_q, cm_dest_d;
  logic [XLEN-1:0]             cm_value_q, cm_value_d;
  logic [TAGW-1:0]             cm_tag_q, cm_tag_d;
  logic [XLEN-1:0]             flush_pc_q, flush_pc_d;

  logic [DEPTH-1:0][TAGW-1:0]  off;
  logic [DEPTH-1:0]            occ;
  logic                        alloc, retire, mispredict;

  assign full   = (count_q == CNTW'(DEPTH));
  assign count  = count_q;
  assign is_tag = tail_q;

  assign alloc  = rdy & is_valid & ~full;
  assign retire = rdy & (count_q != '0) & ready_q[head_q];
  assign mispredict = retire
                    & (op_q[head_q] == BTYPE)
                    & (value_q[head_q][0] != pred_q[head_q]);

  // Entry i is live when its distance from head is below count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      off[i] = TAGW'(i) - head_q;
      occ[i] = {1'b0, off[i]} < count_q;
    end
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    ready_d    = ready_q;
    value_d    = value_q;
    alt_d      = alt_q;
    op_d       = op_q;
    dest_d     = dest_q;
    pred_d     = pred_q;
    cm_reg_d   = 1'b0;
    cm_st_d    = 1'b0;
    flush_d    = 1'b0;
    cm_dest_d  = cm_dest_q;
    cm_value_d = cm_value_q;
    cm_tag_d   = cm_tag_q;
    flush_pc_d = flush_pc_q;

    // Stores wait on the producer tag held in their value field.
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i] && !ready_q[i]) begin
        for (int p = 0; p < NCDB; p++) begin
          if (cdb_valid[p] &&
              ((op_q[i] == STYPE) ? value_q[i][TAGW-1:0]
                                  : TAGW'(i))
              == cdb_tag[p*TAGW +: TAGW]) begin
            ready_d[i] = 1'b1;
            value_d[i] = cdb_result[p*XLEN +: XLEN];
          end
        end
      end
    end

    if (retire) begin
      head_d     = head_q + 1'b1;
      cm_reg_d   = writes_reg(op_q[head_q]);
      cm_st_d    = (op_q[head_q] == STYPE);
      cm_dest_d  = dest_q[head_q];
      cm_value_d = value_q[head_q];
      cm_tag_d   = head_q;
      if (mispredict) begin
        flush_d    = 1'b1;
        flush_pc_d = alt_q[head_q];
      end
    end

    // Tail is never live while alloc is possible, so this overrides CDB.
    if (alloc) begin
      ready_d[tail_q] = is_ready;
      value_d[tail_q] = is_value;
      alt_d[tail_q]   = is_alt_pc;
      op_d[tail_q]    = is_op;
      dest_d[tail_q]  = is_dest;
      pred_d[tail_q]  = is_pred_taken;
      tail_d          = tail_q + 1'b1;
    end

    count_d = count_q + CNTW'(alloc) - CNTW'(retire);

    if (mispredict) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ready_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ready_q    <= '0;
      cm_reg_q   <= 1'b0;
      cm_st_q    <= 1'b0;
      flush_q    <= 1'b0;
      cm_dest_q  <= '0;
      cm_value_q <= '0;
      cm_tag_q   <= '0;
      flush_pc_q <= '0;
    end else if (rdy) begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      cm_reg_q   <= cm_reg_d;
      cm_st_q    <= cm_st_d;
      flush_q    <= flush_d;
      cm_dest_q  <= cm_dest_d;
      cm_value_q <= cm_value_d;
      cm_tag_q   <= cm_tag_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      value_q <= value_d;
      alt_q   <= alt_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      pred_q  <= pred_d;
    end
  end

  assign cm_reg_valid = cm_reg_q;
  assign cm_st_valid  = cm_st_q;
  assign flush        = flush_q;
  assign cm_dest      = cm_dest_q;
  assign cm_value     = cm_value_q;
  assign cm_tag       = cm_tag_q;
  assign flush_pc     = flush_pc_q;

  rob_query_port #(
    .DEPTH (DEPTH),
    .NCDB  (NCDB),
    .XLEN  (XLEN),
    .TAGW  (TAGW)
  ) u_q1 (
    .qtag_i       (qtag1),
    .ready_i      (ready_q),
    .value_i      (value_q),
    .cdb_valid_i  (cdb_valid),
    .cdb_tag_i    (cdb_tag),
    .cdb_result_i (cdb_result),
    .qrdy_o       (qrdy1),
    .qval_o       (qval1)
  );

  rob_query_port #(
    .DEPTH (DEPTH),
    .NCDB  (NCDB),
    .XLEN  (XLEN),
    .TAGW  (TAGW)
  ) u_q2 (
    .qtag_i       (qtag2),
    .ready_i      (ready_q),
    .value_i      (value_q),
    .cdb_valid_i  (cdb_valid),
    .cdb_tag_i    (cdb_tag),
    .cdb_result_i (cdb_result),
    .qrdy_o       (qrdy2),
    .qval_o       (qval2)
  );

endmodule
